// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Captures bytes from an asynchronous serial line and presents them on a
// valid/ready stream. It flags framing errors and bytes dropped on overflow.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   rxd_i         asynchronous serial line, idles high
//   data_o        byte at FIFO head (0 when empty)
//   valid_o       FIFO not empty
//   ready_i       consumer accepts data_o when valid_o & ready_i
//   frame_err_o   one-cycle pulse when a stop bit samples 0
//   overflow_o    one-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count_o  current FIFO occupancy
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 40000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          rxd_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rxs;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;

    logic               push_c;
    logic               pop_c;
    logic               push_ok_c;

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd_i;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM with baud counter; counter restarts on every state change
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            baud_cnt    <= (baud_cnt == BIT_LAST) ? '0 : baud_cnt + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    // Mid start bit: a line back high is a glitch
                    if (baud_cnt == BIT_MID) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            baud_cnt <= '0;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so the next start edge is caught early
                    if (baud_cnt == BIT_LAST) begin
                        state       <= IDLE;
                        baud_cnt    <= '0;
                        frame_err_o <= !rxs;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push_c    = !reset_i && (state == STOP) && (baud_cnt == BIT_LAST) && rxs;
    assign pop_c     = valid_o && ready_i;
    assign push_ok_c = push_c && ((count != OCC_FULL) || pop_c);

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= push_c && !push_ok_c;
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok_c && !pop_c) begin
                count <= count + OCC_W'(1);
            end else if (!push_ok_c && pop_c) begin
                count <= count - OCC_W'(1);
            end
        end
    end

    assign valid_o      = (count != '0);
    assign data_o       = valid_o ? mem[rd_ptr] : 8'h00;
    assign fifo_count_o = count;

endmodule
